time_keeper: RTL and testbench
==============================

# time_keeper

Time-of-day counter feeding the alarm-clock top level: one clock, one-second tick from an internal divider, BCD seconds/minutes/hours outputs. Sits directly upstream of the system controller, which drives its time digits to the display multiplexer, compares them against the alarm time, and loads new time values from the adjust logic. Accepts a one-cycle load of binary hours/minutes and reports a midnight rollover.

## Interface
- TICK_DIV, 100000000: clock cycles per one-second tick; minimum 2; benches use small values.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- enable  in  1  count enable; low freezes the divider and all digits.
- load  in  1  one-cycle pulse; load load_hours:load_minutes, seconds := 00.
- load_minutes  in  6  binary minutes, 0..59.
- load_hours  in  5  binary hours, 0..23, always 24-hour.
- sec_units, sec_tens  out  4 each  BCD seconds.
- min_units, min_tens  out  4 each  BCD minutes.
- hour_units, hour_tens  out  4 each  BCD hours.
- sec_pulse  out  1  one-cycle pulse in the cycle a tick-driven new second first appears.
- rollover  out  1  one-cycle pulse coincident with the 23:59:59 -> 00:00:00 step.
- load_err  out  1  one-cycle pulse when a load is rejected.
- pm  out  1  only with TIME_KEEPER_12H_EN; high when internal hour >= 12.

## Operation
- Reset: divider 0, time 00:00:00, sec_pulse/rollover/load_err 0, pm 0; in 12H mode hour digits read 12.
- Divider: counts 0..TICK_DIV-1 while enable; at TICK_DIV-1 wraps to 0 and issues an internal tick.
- Tick: seconds +1; 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours; hours 23 -> 00 raises rollover.
- BCD per field: units 9 -> 0 increments tens; tens wrap at field limit (5 for sec/min, hour pair wraps at 23).
- Load valid (minutes <= 59 and hours <= 23): hours/minutes converted to BCD, seconds := 00, divider := 0, no sec_pulse/rollover.
- Load invalid: time and divider unchanged, load_err pulses.
- Load and tick in same cycle: load wins; tick discarded.
- Load accepted regardless of enable.
- enable low: divider holds its value (does not clear); resuming continues the partial second.
- Internal state always 24-hour; outputs are registers, no combinational path from inputs.

## Timing
- Load sampled at edge N -> new digits visible after edge N (cycle N+1); load_err in same cycle.
- After reset or valid load, first tick after exactly TICK_DIV enabled cycles.
- sec_pulse/rollover high for exactly one cycle, aligned with the updated digits.
- All six digits update on the same edge; no intermediate values visible.
- rst asserted mid-count or coincident with load/tick: reset wins.

## Configuration
- TIME_KEEPER_12H_EN defined: hour digits show 12-hour form (00 -> 12, 13..23 -> 01..11, 12 stays 12), pm port present and registered with the digits; load inputs and rollover remain 24-hour semantics.
- Undefined: hour digits 00..23, pm port absent.

## Structure
- Package time_keeper_pkg: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, 4-bit BCD digit type, bin-to-BCD function for 0..59.
- Sub-module bcd_mod_counter: two-digit BCD counter with parameterised limit, inc, load, carry_out; instantiated for seconds, minutes, hours.
- Divider and 12H mapping stay in time_keeper.

## Test plan
- TICK_DIV=4, rst then enable high 4 cycles -> digits 00:00:01, sec_pulse one cycle.
- load 23:59, 60 enabled ticks -> 00:00:00, rollover one cycle, sec_pulse same cycle.
- load_minutes=60 or load_hours=24 -> load_err one cycle, time unchanged.
- load coincident with tick at 10:15 -> 10:15:00, no sec_pulse, next tick after 4 cycles.
- enable low for 10 cycles after 2 enabled cycles -> frozen; tick after 2 more enabled cycles.
- TIME_KEEPER_12H_EN, load 00:30 -> hour digits 12, pm 0; load 13:05 -> 01, pm 1.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared limits, BCD digit types and binary-to-BCD conversion for time_keeper.
package time_keeper_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

  // Valid for 0..59; callers range-check before converting.
  function automatic bcd_pair_t bin_to_bcd(input logic [5:0] value);
    bcd_pair_t result;
    result.tens  = 4'(value / 6'd10);
    result.units = 4'(value % 6'd10);
    return result;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_mod_counter.sv
// Two-digit BCD counter wrapping from LIMIT to 00, with synchronous load and
// a carry that marks the wrap step.
module bcd_mod_counter
  import time_keeper_pkg::*;
#(
  parameter int LIMIT = 59
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      load,
  input  bcd_pair_t load_value,
  output bcd_pair_t count,
  output logic      carry_out
);

  localparam bcd_digit_t LIMIT_TENS  = 4'(LIMIT / 10);
  localparam bcd_digit_t LIMIT_UNITS = 4'(LIMIT % 10);

  bcd_pair_t count_reg;
  bcd_pair_t count_next;
  logic      at_limit;

  assign at_limit  = (count_reg.tens == LIMIT_TENS) && (count_reg.units == LIMIT_UNITS);
  assign carry_out = inc && at_limit;
  assign count     = count_reg;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (inc) begin
      if (at_limit) begin
        count_next = '0;
      end else if (count_reg.units == 4'd9) begin
        count_next.units = 4'd0;
        count_next.tens  = count_reg.tens + 4'd1;
      end else begin
        count_next.units = count_reg.units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter with one-second divider, BCD digits and binary load.
// Optional 12-hour display with pm flag when TIME_KEEPER_12H_EN is defined.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [5:0] load_minutes,
  input  logic [4:0] load_hours,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic [3:0] hour_units,
  output logic [3:0] hour_tens,
  output logic       sec_pulse,
  output logic       rollover,
  output logic       load_err
`ifdef TIME_KEEPER_12H_EN
  , output logic     pm
`endif
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic             load_ok;
  logic             sec_carry, min_carry, hour_carry;
  bcd_pair_t        sec_count, min_count, hour_count;
  logic             sec_pulse_reg, rollover_reg, load_err_reg;

  assign load_ok = load && (load_minutes <= 6'(MIN_MAX)) && (load_hours <= 5'(HOUR_MAX));
  // Any load, accepted or not, suppresses the tick of that cycle.
  assign tick    = enable && !load && (div_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (load_ok) begin
      div_reg <= '0;
    end else if (enable && !load) begin
      div_reg <= tick ? '0 : div_reg + DIV_W'(1);
    end
  end

  bcd_mod_counter #(.LIMIT(SEC_MAX)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .inc        (tick),
    .load       (load_ok),
    .load_value ('0),
    .count      (sec_count),
    .carry_out  (sec_carry)
  );

  bcd_mod_counter #(.LIMIT(MIN_MAX)) u_min (
    .clk        (clk),
    .rst        (rst),
    .inc        (sec_carry),
    .load       (load_ok),
    .load_value (bin_to_bcd(load_minutes)),
    .count      (min_count),
    .carry_out  (min_carry)
  );

  bcd_mod_counter #(.LIMIT(HOUR_MAX)) u_hour (
    .clk        (clk),
    .rst        (rst),
    .inc        (min_carry),
    .load       (load_ok),
    .load_value (bin_to_bcd({1'b0, load_hours})),
    .count      (hour_count),
    .carry_out  (hour_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_pulse_reg <= 1'b0;
      rollover_reg  <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      sec_pulse_reg <= tick;
      rollover_reg  <= hour_carry;
      load_err_reg  <= load && !load_ok;
    end
  end

  assign sec_units = sec_count.units;
  assign sec_tens  = sec_count.tens;
  assign min_units = min_count.units;
  assign min_tens  = min_count.tens;
  assign sec_pulse = sec_pulse_reg;
  assign rollover  = rollover_reg;
  assign load_err  = load_err_reg;

`ifdef TIME_KEEPER_12H_EN
  // A binary shadow of the hour lets the 12-hour digits and pm be registered
  // on the same edge as the 24-hour counters.
  logic [4:0] hour_bin_reg, hour_bin_next;
  logic [4:0] hour12;
  bcd_pair_t  disp_hour_reg;
  logic       pm_reg;

  always_comb begin
    hour_bin_next = hour_bin_reg;
    if (load_ok) begin
      hour_bin_next = load_hours;
    end else if (min_carry) begin
      hour_bin_next = (hour_bin_reg == 5'(HOUR_MAX)) ? 5'd0 : hour_bin_reg + 5'd1;
    end
    hour12 = hour_bin_next;
    if (hour_bin_next == 5'd0) begin
      hour12 = 5'd12;
    end else if (hour_bin_next > 5'd12) begin
      hour12 = hour_bin_next - 5'd12;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_bin_reg  <= '0;
      disp_hour_reg <= '{tens: 4'd1, units: 4'd2};
      pm_reg        <= 1'b0;
    end else begin
      hour_bin_reg  <= hour_bin_next;
      disp_hour_reg <= bin_to_bcd({1'b0, hour12});
      pm_reg        <= (hour_bin_next >= 5'd12);
    end
  end

  assign hour_units = disp_hour_reg.units;
  assign hour_tens  = disp_hour_reg.tens;
  assign pm         = pm_reg;
`else
  assign hour_units = hour_count.units;
  assign hour_tens  = hour_count.tens;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4; covers TIME_KEEPER_12H_EN
// hour mapping when that macro is defined.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst, enable, load;
  logic [5:0] load_minutes;
  logic [4:0] load_hours;
  logic [3:0] sec_units, sec_tens, min_units, min_tens, hour_units, hour_tens;
  logic       sec_pulse, rollover, load_err;
`ifdef TIME_KEEPER_12H_EN
  logic       pm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_keeper #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .load         (load),
    .load_minutes (load_minutes),
    .load_hours   (load_hours),
    .sec_units    (sec_units),
    .sec_tens     (sec_tens),
    .min_units    (min_units),
    .min_tens     (min_tens),
    .hour_units   (hour_units),
    .hour_tens    (hour_tens),
    .sec_pulse    (sec_pulse),
    .rollover     (rollover),
    .load_err     (load_err)
`ifdef TIME_KEEPER_12H_EN
    , .pm         (pm)
`endif
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic logic [7:0] hour_digits(input int h);
    int d = h;
`ifdef TIME_KEEPER_12H_EN
    if (d == 0) d = 12;
    else if (d > 12) d = d - 12;
`endif
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  // Compares all six digits packed as hh:mm:ss hex-BCD.
  task automatic check_time(input string tag, input int h, input int m, input int s);
    logic [23:0] observed, expected;
    observed = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
    expected = {hour_digits(h), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    check(tag, int'(observed), int'(expected));
  endtask

  task automatic do_load(input int h, input int m);
    load = 1'b1;
    load_hours = 5'(h);
    load_minutes = 6'(m);
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; load_minutes = '0; load_hours = '0;
    step(2);
    rst = 1'b0;
    check_time("reset_time", 0, 0, 0);
    check("reset_flags", int'({sec_pulse, rollover, load_err}), 0);

    // First tick after exactly four enabled cycles.
    enable = 1'b1;
    step(3);
    check_time("pre_first_tick", 0, 0, 0);
    check("pre_first_pulse", int'(sec_pulse), 0);
    step(1);
    check_time("first_tick", 0, 0, 1);
    check("first_pulse", int'(sec_pulse), 1);
    step(1);
    check("first_pulse_end", int'(sec_pulse), 0);

    // Midnight rollover after 60 ticks from 23:59:00.
    do_load(23, 59);
    check_time("load_2359", 23, 59, 0);
    check("load_2359_pulse", int'(sec_pulse), 0);
    step(239);
    check_time("pre_midnight", 23, 59, 59);
    check("pre_midnight_roll", int'(rollover), 0);
    step(1);
    check_time("midnight", 0, 0, 0);
    check("midnight_flags", int'({sec_pulse, rollover}), 2'b11);
    step(1);
    check("midnight_roll_end", int'(rollover), 0);

    // Rejected loads.
    enable = 1'b0;
    do_load(5, 60);
    check("err_min60", int'(load_err), 1);
    check_time("err_min60_time", 0, 0, 0);
    step(1);
    check("err_min60_end", int'(load_err), 0);
    do_load(24, 10);
    check("err_hour24", int'(load_err), 1);
    check_time("err_hour24_time", 0, 0, 0);

    // Load coincident with a tick wins.
    enable = 1'b1;
    do_load(8, 0);
    step(3);
    check_time("pre_coincide", 8, 0, 0);
    do_load(10, 15);
    check_time("coincide_load", 10, 15, 0);
    check("coincide_no_pulse", int'({sec_pulse, load_err}), 0);
    step(3);
    check_time("coincide_pre_tick", 10, 15, 0);
    step(1);
    check_time("coincide_tick", 10, 15, 1);
    check("coincide_tick_pulse", int'(sec_pulse), 1);

    // Freeze keeps the partial second.
    step(2);
    enable = 1'b0;
    step(10);
    check_time("frozen", 10, 15, 1);
    check("frozen_pulse", int'(sec_pulse), 0);
    enable = 1'b1;
    step(1);
    check_time("resume_1", 10, 15, 1);
    step(1);
    check_time("resume_2", 10, 15, 2);
    check("resume_pulse", int'(sec_pulse), 1);

    // Reset wins over a coincident load.
    rst = 1'b1;
    do_load(10, 15);
    rst = 1'b0;
    check_time("reset_vs_load", 0, 0, 0);

    // Hour units 9 -> tens carry.
    do_load(19, 59);
    step(240);
    check_time("carry_2000", 20, 0, 0);

`ifdef TIME_KEEPER_12H_EN
    enable = 1'b0;
    do_load(0, 30);
    check_time("h12_0030", 0, 30, 0);
    check("h12_0030_pm", int'(pm), 0);
    do_load(13, 5);
    check_time("h12_1305", 13, 5, 0);
    check("h12_1305_pm", int'(pm), 1);
    do_load(12, 0);
    check_time("h12_1200", 12, 0, 0);
    check("h12_1200_pm", int'(pm), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
